ar_rx: RTL and testbench
========================

# ar_rx

Serial word receiver for the bipolar return-to-zero link that carries 32-bit address/data words: an 8-bit address, 23-bit data and an odd parity bit. It sits at the receiving end of the line driven by the transmitter of the same link. It synchronises the two line wires, deserialises the word and checks length, parity and line integrity. It then presents the received address and data with a one-clock write strobe to the downstream register/display logic.

## Interface
- Fclk, 50_000_000, system clock frequency in Hz; used to derive the inter-word gap timeout.
- clk  in  1  system clock; all logic on its rising edge.
- rst  in  1  reset; asynchronous, active-high.
- In1  in  1  line wire "1": an RZ pulse here is a logic-1 bit; asynchronous to clk.
- In0  in  1  line wire "0": an RZ pulse here is a logic-0 bit; asynchronous to clk.
- VEL  in  2  bit-rate select: 11 = 100 kbit/s, 10 = 50 kbit/s, 01 and 00 = 12.5 kbit/s; must be static during a word.
- ADR  out 8  address of the last complete word.
- DAT  out 23 data of the last complete word.
- ok  out 1  parity of the last complete word was correct (odd).
- ce_wr  out 1  one-clock strobe: ADR, DAT and ok were just updated.
- err  out 1  one-clock strobe: the word was aborted (short word, line fault or early pulse).

## Operation
- Serial order: ADR[7] first, down to ADR[0], then DAT[22] down to DAT[0], then P. The total count of ones over all 32 bits is odd on a correct word.
- Each wire passes through a two-flop synchroniser s1→s2, followed by a history flop s3. A bit edge is (s2_1|s2_0) & ~(s3_1|s3_0).
- At a bit edge:
  - If exactly one synchronised wire is high, the bit value is s2_1.
  - If both are high, it is a line fault.
- Gap counter, 16 bits:
  - Cleared on every bit edge; otherwise increments, saturating at all-ones.
  - Timeout fires when the counter equals TGAP−1.
  - TGAP = 2·Fclk/rate: 1000 clocks at 100 kbit/s, 2000 at 50 kbit/s, 8000 at 12.5 kbit/s with the default Fclk.
- 5-bit bit counter and 32-bit shift register.
- States:
  - IDLE: waiting for the first bit.
    - Valid edge: shift the bit in, count = 1, go to RECV.
    - Line fault: pulse err, go to GAP.
    - Timeout is ignored.
  - RECV: receiving bits 2..32.
    - Valid edge with count < 31: shift the bit in, count+1.
    - Valid edge completing bit 32: load ADR, DAT and ok = ^{word} (reduction XOR of the 32 bits), pulse ce_wr, go to GAP.
    - Line fault: pulse err, go to GAP.
    - Timeout: pulse err, go to IDLE.
  - GAP: waiting for the inter-word gap.
    - Any edge: pulse err, restart the gap counter, stay in GAP.
    - Timeout: go to IDLE.
- ADR, DAT and ok change only together with ce_wr. A bad-parity word is still delivered, with ok = 0.
- err and ce_wr are never high in the same cycle.
- Reset at any time discards any partial word and returns to IDLE. The next word is received normally.

## Timing
- Reset values:
  - ADR = 0, DAT = 0, ok = 0, ce_wr = 0, err = 0.
  - State IDLE, counters 0, synchroniser flops 0.
- Latency: let clock edge k be the first edge that samples the 32nd pulse high on a pin.
  - ADR, DAT, ok and ce_wr update at edge k+2.
  - ce_wr is high for exactly one clock.
  - The same latency applies to err on a line fault.
- Timeout err: asserted at the edge where the counter reaches TGAP−1 after the last edge, and lasts one clock.
- Minimum RZ pulse width on the pins: 2 clocks. The line gap (both wires low) between pulses must also be at least 2 clocks.
- Back-to-back words need at least TGAP clocks of idle between the last pulse of one word and the first pulse of the next, measured edge to edge. The link standard gap of 4 bit times satisfies this.

## Test plan
- VEL=11: send ADR=8'h84, DAT=23'h112200, P=1 → one ce_wr pulse, ADR=8'h84, DAT=23'h112200, ok=1, err never high.
- VEL=11: send ADR=8'h84, DAT=23'h110200 with P=1 (wrong; correct P=0) → ce_wr pulse, DAT=23'h110200, ok=0. Then resend the same word with P=0 after a 4-bit gap → ok=1.
- VEL=10: send 20 bits and stop → err pulse 2000 clocks after the 20th bit edge, no ce_wr, ADR/DAT keep their previous values. The next full word is received correctly.
- Raise In1 and In0 together at bit 5 → err pulse 2 clocks later, no ce_wr. A new word starting before TGAP has elapsed gives another err. A new word after the gap is received correctly.
- A second word starting only 1 bit time after a complete word → err on its first pulse. No ce_wr for the early word until a full gap has elapsed.
- Assert rst for 3 clocks during bit 16 → all outputs 0 and the state is IDLE. The following full word (8'h84, 23'h112200) gives ce_wr with ok=1.

Source files
------------

// File: rtl/ar_rx.sv
// Bipolar RZ serial receiver: synchronises the In1/In0 line pair and deserialises 32-bit words (8-bit address, 23-bit data, odd parity).
// Word outputs update two clocks after the final pulse is first sampled; the line has no backpressure.
module ar_rx #(
  parameter int Fclk = 50_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        In1,
  input  logic        In0,
  input  logic [1:0]  VEL,
  output logic [7:0]  ADR,
  output logic [22:0] DAT,
  output logic        ok,
  output logic        ce_wr,
  output logic        err
);

  localparam int TG_FAST = 2 * Fclk / 100_000;
  localparam int TG_MID  = 2 * Fclk / 50_000;
  localparam int TG_SLOW = 2 * Fclk / 12_500;

  localparam logic [15:0] TG_FAST_M1 = 16'(TG_FAST - 1);
  localparam logic [15:0] TG_MID_M1  = 16'(TG_MID - 1);
  localparam logic [15:0] TG_SLOW_M1 = 16'(TG_SLOW - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RECV = 2'd1,
    GAP  = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic s1_1, s2_1, s3_1;
  logic s1_0, s2_0, s3_0;

  logic        bit_edge;
  logic        line_fault;
  logic        bit_val;
  logic        valid_bit;
  logic [15:0] gap_cnt;
  logic [15:0] tgap_m1;
  logic        timeout;
  logic [4:0]  bit_cnt;
  logic [30:0] shreg;
  logic [31:0] word;

  logic shift_en;
  logic load_word;
  logic err_nxt;

  // s1/s2 resolve metastability; s3 is history for rising-edge detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_1 <= 1'b0;
      s2_1 <= 1'b0;
      s3_1 <= 1'b0;
      s1_0 <= 1'b0;
      s2_0 <= 1'b0;
      s3_0 <= 1'b0;
    end else begin
      s1_1 <= In1;
      s2_1 <= s1_1;
      s3_1 <= s2_1;
      s1_0 <= In0;
      s2_0 <= s1_0;
      s3_0 <= s2_0;
    end
  end

  assign bit_edge   = (s2_1 | s2_0) & ~(s3_1 | s3_0);
  assign line_fault = bit_edge & s2_1 & s2_0;
  assign valid_bit  = bit_edge & ~(s2_1 & s2_0);
  assign bit_val    = s2_1;
  assign word       = {shreg, bit_val};

  always_comb begin
    case (VEL)
      2'b11:   tgap_m1 = TG_FAST_M1;
      2'b10:   tgap_m1 = TG_MID_M1;
      default: tgap_m1 = TG_SLOW_M1;
    endcase
  end

  assign timeout = (gap_cnt == tgap_m1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gap_cnt <= '0;
    end else if (bit_edge) begin
      gap_cnt <= '0;
    end else if (gap_cnt != 16'hFFFF) begin
      gap_cnt <= gap_cnt + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // A pulse always wins over a timeout in the same cycle
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (valid_bit) begin
          state_nxt = RECV;
        end else if (line_fault) begin
          state_nxt = GAP;
        end
      end
      RECV: begin
        if (line_fault) begin
          state_nxt = GAP;
        end else if (valid_bit) begin
          if (bit_cnt == 5'd31) begin
            state_nxt = GAP;
          end
        end else if (timeout) begin
          state_nxt = IDLE;
        end
      end
      GAP: begin
        if (!bit_edge && timeout) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    shift_en  = 1'b0;
    load_word = 1'b0;
    err_nxt   = 1'b0;
    case (state)
      IDLE: begin
        shift_en = valid_bit;
        err_nxt  = line_fault;
      end
      RECV: begin
        if (line_fault) begin
          err_nxt = 1'b1;
        end else if (valid_bit) begin
          if (bit_cnt == 5'd31) begin
            load_word = 1'b1;
          end else begin
            shift_en = 1'b1;
          end
        end else if (timeout) begin
          err_nxt = 1'b1;
        end
      end
      GAP: begin
        err_nxt = bit_edge;
      end
      default: begin
        shift_en  = 1'b0;
        load_word = 1'b0;
        err_nxt   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_cnt <= '0;
      shreg   <= '0;
    end else if (shift_en) begin
      bit_cnt <= (state == IDLE) ? 5'd1 : bit_cnt + 5'd1;
      shreg   <= word[30:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ADR   <= '0;
      DAT   <= '0;
      ok    <= 1'b0;
      ce_wr <= 1'b0;
      err   <= 1'b0;
    end else begin
      ce_wr <= load_word;
      err   <= err_nxt;
      if (load_word) begin
        ADR <= word[31:24];
        DAT <= word[23:1];
        ok  <= ^word;
      end
    end
  end

endmodule

// File: tb/tb_ar_rx.sv
// Directed bench for ar_rx: full words, parity, timeout, line fault, early word and mid-word reset.
module tb_ar_rx;

  logic        clk = 1'b0;
  logic        rst;
  logic        In1;
  logic        In0;
  logic [1:0]  VEL;
  logic [7:0]  ADR;
  logic [22:0] DAT;
  logic        ok;
  logic        ce_wr;
  logic        err;

  int cyc       = 0;
  int ce_cnt    = 0;
  int err_cnt   = 0;
  int both_cnt  = 0;
  int last_ce   = -1;
  int last_err  = -1;
  int last_rise = 0;
  int t_mark    = 0;
  int total     = 0;
  int passes    = 0;

  localparam logic [31:0] W1 = {8'h84, 23'h112200, 1'b1};
  localparam logic [31:0] W2 = {8'h84, 23'h110200, 1'b1};
  localparam logic [31:0] W3 = {8'h84, 23'h110200, 1'b0};
  localparam logic [31:0] W4 = {8'h3C, 23'h055AA5, 1'b1};
  localparam logic [31:0] W5 = {8'hC3, 23'h0000FF, 1'b1};

  ar_rx #(.Fclk(50_000_000)) dut (
    .clk   (clk),
    .rst   (rst),
    .In1   (In1),
    .In0   (In0),
    .VEL   (VEL),
    .ADR   (ADR),
    .DAT   (DAT),
    .ok    (ok),
    .ce_wr (ce_wr),
    .err   (err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (ce_wr) begin
      ce_cnt++;
      last_ce = cyc;
    end
    if (err) begin
      err_cnt++;
      last_err = cyc;
    end
    if (ce_wr && err) both_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: got %0h want %0h", tag, obs, exp);
  endtask

  task automatic send_bit(input logic b);
    @(posedge clk);
    #1;
    if (b) In1 = 1'b1;
    else   In0 = 1'b1;
    last_rise = cyc;
    repeat (4) @(posedge clk);
    #1;
    In1 = 1'b0;
    In0 = 1'b0;
    repeat (3) @(posedge clk);
  endtask

  task automatic send_fault();
    @(posedge clk);
    #1;
    In1 = 1'b1;
    In0 = 1'b1;
    last_rise = cyc;
    repeat (4) @(posedge clk);
    #1;
    In1 = 1'b0;
    In0 = 1'b0;
    repeat (3) @(posedge clk);
  endtask

  task automatic send_bits(input logic [31:0] w, input int n);
    for (int i = 31; i > 31 - n; i--) send_bit(w[i]);
  endtask

  task automatic gap(input int n);
    repeat (n) @(posedge clk);
  endtask

  initial begin
    rst = 1'b1;
    In1 = 1'b0;
    In0 = 1'b0;
    VEL = 2'b11;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_adr", ADR, 8'h00);
    chk("rst_dat", DAT, 23'h0);
    chk("rst_ok", ok, 1'b0);
    chk("rst_ce", ce_wr, 1'b0);
    chk("rst_err", err, 1'b0);

    // good word at 100 kbit/s
    send_bits(W1, 32);
    @(negedge clk);
    chk("w1_ce_cnt", ce_cnt, 1);
    chk("w1_ce_lat", last_ce, last_rise + 3);
    chk("w1_adr", ADR, 8'h84);
    chk("w1_dat", DAT, 23'h112200);
    chk("w1_ok", ok, 1'b1);
    chk("w1_err_cnt", err_cnt, 0);
    gap(1100);

    // wrong parity still delivered, then corrected resend
    send_bits(W2, 32);
    @(negedge clk);
    chk("w2_ce_cnt", ce_cnt, 2);
    chk("w2_dat", DAT, 23'h110200);
    chk("w2_ok", ok, 1'b0);
    gap(2000);
    send_bits(W3, 32);
    @(negedge clk);
    chk("w3_ce_cnt", ce_cnt, 3);
    chk("w3_dat", DAT, 23'h110200);
    chk("w3_ok", ok, 1'b1);
    chk("w3_err_cnt", err_cnt, 0);
    gap(1100);

    // short word at 50 kbit/s times out
    VEL = 2'b10;
    gap(10);
    send_bits(W4, 20);
    t_mark = last_rise;
    gap(2100);
    @(negedge clk);
    chk("to_err_cnt", err_cnt, 1);
    chk("to_err_time", last_err, t_mark + 2003);
    chk("to_ce_cnt", ce_cnt, 3);
    chk("to_adr_hold", ADR, 8'h84);
    chk("to_dat_hold", DAT, 23'h110200);
    send_bits(W4, 32);
    @(negedge clk);
    chk("w4_ce_cnt", ce_cnt, 4);
    chk("w4_adr", ADR, 8'h3C);
    chk("w4_dat", DAT, 23'h055AA5);
    chk("w4_ok", ok, 1'b1);
    chk("w4_err_cnt", err_cnt, 1);
    gap(2100);

    // both wires high at bit 5
    VEL = 2'b11;
    gap(10);
    send_bits(W1, 4);
    send_fault();
    @(negedge clk);
    chk("lf_err_cnt", err_cnt, 2);
    chk("lf_err_lat", last_err, last_rise + 3);
    chk("lf_ce_cnt", ce_cnt, 4);
    send_bit(1'b1);
    @(negedge clk);
    chk("lf_early_err", err_cnt, 3);
    chk("lf_early_lat", last_err, last_rise + 3);
    gap(1100);
    send_bits(W1, 32);
    @(negedge clk);
    chk("lf_rec_ce", ce_cnt, 5);
    chk("lf_rec_adr", ADR, 8'h84);
    chk("lf_rec_dat", DAT, 23'h112200);
    chk("lf_rec_err", err_cnt, 3);

    // next word starts one bit time after a complete word
    gap(500);
    send_bits(W5, 3);
    @(negedge clk);
    chk("early_err_cnt", err_cnt, 6);
    chk("early_ce_cnt", ce_cnt, 5);
    gap(1100);
    send_bits(W5, 32);
    @(negedge clk);
    chk("w5_ce_cnt", ce_cnt, 6);
    chk("w5_adr", ADR, 8'hC3);
    chk("w5_dat", DAT, 23'h0000FF);
    chk("w5_ok", ok, 1'b1);
    gap(1100);

    // reset in the middle of a word
    send_bits(W1, 15);
    @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("mrst_adr", ADR, 8'h00);
    chk("mrst_dat", DAT, 23'h0);
    chk("mrst_ok", ok, 1'b0);
    chk("mrst_ce", ce_wr, 1'b0);
    chk("mrst_err", err, 1'b0);
    send_bits(W1, 32);
    @(negedge clk);
    chk("post_ce_cnt", ce_cnt, 7);
    chk("post_adr", ADR, 8'h84);
    chk("post_dat", DAT, 23'h112200);
    chk("post_ok", ok, 1'b1);
    chk("post_err_cnt", err_cnt, 6);
    chk("ce_err_overlap", both_cnt, 0);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
